// File: rtl/ram_fifo_pkg.sv
// Shared types and default widths for the external-RAM FIFO controller.
// Read FSM: RD_IDLE issues a RAM read, RD_WAIT captures the returned word.
package ram_fifo_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_t;

  localparam int unsigned DEF_ADDRWIDTH = 8;
  localparam int unsigned DEF_DATAWIDTH = 8;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller storing words in an external single-port RAM; optional flush via RAM_FIFO_CTRL_FLUSH_EN.
// Latency: 3 cycles from push into empty FIFO to pop_valid (write, read issue, capture); 1 pop per 2 cycles.
// Backpressure: push_ready drops when RAM full, while a read takes the port, or during flush; pop_data holds while stalled.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned addrwidth = DEF_ADDRWIDTH,
  parameter int unsigned datawidth = DEF_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [datawidth-1:0] push_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [datawidth-1:0] pop_data,
  output logic [addrwidth+1:0] count,
  output logic [addrwidth-1:0] ram_address,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [datawidth-1:0] ram_data_in,
  input  logic [datawidth-1:0] ram_data_out
);

  localparam int unsigned          DEPTH     = 2 ** addrwidth;
  localparam logic [addrwidth:0]   DEPTH_CNT = (addrwidth + 1)'(DEPTH);
  localparam logic [addrwidth-1:0] PTR_ONE   = (addrwidth)'(1);
  localparam logic [addrwidth:0]   CNT_ONE   = (addrwidth + 1)'(1);

  rd_state_t            state_q, state_d;
  logic [addrwidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [addrwidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [addrwidth:0]   ram_count_q, ram_count_d;
  logic                 pop_valid_q, pop_valid_d;
  logic [datawidth-1:0] pop_data_q, pop_data_d;

  logic flush_w;
  logic rd_issue;
  logic push_fire;
  logic pop_fire;

`ifdef RAM_FIFO_CTRL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Gating with rst keeps the RAM port quiet while reset is held, even if push_valid is high.
  always_comb begin
    rd_issue   = rst && !flush_w && (state_q == RD_IDLE) && (ram_count_q != '0)
                 && (!pop_valid_q || pop_ready);
    push_ready = rst && !flush_w && (ram_count_q < DEPTH_CNT) && !rd_issue;
    push_fire  = push_valid && push_ready;
    pop_fire   = pop_valid_q && pop_ready;
  end

  always_comb begin
    ram_ren     = rd_issue;
    ram_wen     = push_fire;
    ram_address = '0;
    ram_data_in = '0;
    if (rd_issue) begin
      ram_address = rd_ptr_q;
    end else if (push_fire) begin
      ram_address = wr_ptr_q;
      ram_data_in = push_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;

    if (flush_w) begin
      state_d     = RD_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      pop_valid_d = 1'b0;
      pop_data_d  = '0;
    end else begin
      state_d = rd_issue ? RD_WAIT : RD_IDLE;

      if (rd_issue) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        ram_count_d = ram_count_q - CNT_ONE;
      end else if (push_fire) begin
        wr_ptr_d    = wr_ptr_q + PTR_ONE;
        ram_count_d = ram_count_q + CNT_ONE;
      end

      // A read is only issued when the output register is empty or draining, so the capture never overwrites live data.
      if (state_q == RD_WAIT) begin
        pop_valid_d = 1'b1;
        pop_data_d  = ram_data_out;
      end else if (pop_fire) begin
        pop_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RD_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign count     = (addrwidth + 2)'(ram_count_q)
                   + (addrwidth + 2)'(state_q == RD_WAIT)
                   + (addrwidth + 2)'(pop_valid_q);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl at addrwidth=2, datawidth=8 with a behavioural RAM and a queue scoreboard.
// Directed vectors pin cycle timing; a per-cycle monitor checks occupancy, ordering and RAM port rules.
module tb_ram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_address;
  logic          ram_ren;
  logic          ram_wen;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
  logic          flush;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] model_q [$];
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.addrwidth(AW), .datawidth(DW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    .flush        (flush),
`endif
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_data    (push_data),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_data     (pop_data),
    .count        (count),
    .ram_address  (ram_address),
    .ram_ren      (ram_ren),
    .ram_wen      (ram_wen),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wen) mem[ram_address] <= ram_data_in;
    if (ram_ren) ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    int w;
    push_valid = 1'b1;
    push_data  = d;
    #1;
    w = 0;
    while (!push_ready && w < 16) begin
      tick();
      w++;
    end
    chk("push_accept", 32'(push_ready), 32'd1);
    tick();
    push_valid = 1'b0;
  endtask

  // Occupancy = accepted pushes - accepted pops; k-th write/read uses address k mod DEPTH.
  task automatic monitor();
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        prev_stall = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_pop_data", 32'(pop_data), 32'd0);
        chk("rst_ram_en", 32'({ram_ren, ram_wen}), 32'd0);
        chk("rst_ram_bus", 32'({ram_address, ram_data_in}), 32'd0);
      end else begin
        chk("count_model", 32'(count), 32'(model_q.size()));
        chk("ren_wen_excl", 32'(ram_ren && ram_wen), 32'd0);
        if (!ram_ren && !ram_wen) chk("idle_ram_bus", 32'({ram_address, ram_data_in}), 32'd0);
        chk("wen_is_push", 32'(ram_wen), 32'(push_valid && push_ready));
        if (ram_wen) begin
          chk("wr_addr", 32'(ram_address), 32'(wr_cnt % DEPTH));
          chk("wr_data", 32'(ram_data_in), 32'(push_data));
        end
        if (ram_ren) chk("rd_addr", 32'(ram_address), 32'(rd_cnt % DEPTH));
        if (prev_stall) begin
          chk("hold_valid", 32'(pop_valid), 32'd1);
          chk("hold_data", 32'(pop_data), 32'(prev_data));
        end
        if (pop_valid && pop_ready) begin
          chk("pop_nonempty", 32'(model_q.size() > 0), 32'd1);
          if (model_q.size() > 0) begin
            chk("pop_order", 32'(pop_data), 32'(model_q[0]));
            void'(model_q.pop_front());
          end
        end
        if (ram_ren) rd_cnt++;
        if (push_valid && push_ready) begin
          model_q.push_back(push_data);
          wr_cnt++;
        end
        prev_stall = pop_valid && !pop_ready;
        prev_data  = pop_data;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
        if (flush) begin
          model_q.delete();
          wr_cnt = 0;
          rd_cnt = 0;
          prev_stall = 1'b0;
        end
`endif
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    flush      = 1'b0;
`endif
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset and idle
    repeat (3) tick();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_pop_valid", 32'(pop_valid), 32'd0);
    chk("reset_ram_en", 32'({ram_ren, ram_wen}), 32'd0);
    rst = 1'b1;
    #1;
    chk("push_ready_after_rst", 32'(push_ready), 32'd1);
    tick();
    tick();
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_pop_valid", 32'(pop_valid), 32'd0);
    chk("idle_push_ready", 32'(push_ready), 32'd1);
    chk("idle_ram_en", 32'({ram_ren, ram_wen}), 32'd0);

    // First-word latency
    tick();
    push_valid = 1'b1;
    push_data  = 8'hA1;
    pop_ready  = 1'b1;
    #1;
    chk("c0_wen", 32'(ram_wen), 32'd1);
    chk("c0_addr", 32'(ram_address), 32'd0);
    chk("c0_data_in", 32'(ram_data_in), 32'hA1);
    tick();
    push_valid = 1'b0;
    #1;
    chk("c1_ren", 32'(ram_ren), 32'd1);
    chk("c1_addr", 32'(ram_address), 32'd0);
    chk("c1_count", 32'(count), 32'd1);
    tick();
    chk("c2_pop_valid", 32'(pop_valid), 32'd0);
    tick();
    chk("c3_pop_valid", 32'(pop_valid), 32'd1);
    chk("c3_pop_data", 32'(pop_data), 32'hA1);
    tick();
    chk("c4_pop_valid", 32'(pop_valid), 32'd0);
    chk("c4_count", 32'(count), 32'd0);

    // Fill with pop stalled
    pop_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(8'(8'h10 + i));
    push_valid = 1'b1;
    push_data  = 8'h15;
    repeat (3) begin
      #1;
      chk("full_push_ready", 32'(push_ready), 32'd0);
      chk("full_count", 32'(count), 32'd5);
      chk("full_pop_valid", 32'(pop_valid), 32'd1);
      chk("full_pop_data", 32'(pop_data), 32'h10);
      chk("full_wen", 32'(ram_wen), 32'd0);
      tick();
    end

    // Drain: one word per two cycles, read addresses 2,3,0,1
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_pop_valid", 32'(pop_valid), 32'd1);
      chk("drain_pop_data", 32'(pop_data), 32'(8'h10 + k));
      if (k < 4) begin
        chk("drain_ren", 32'(ram_ren), 32'd1);
        chk("drain_addr", 32'(ram_address), 32'((k + 2) % DEPTH));
      end else begin
        chk("drain_last_no_ren", 32'(ram_ren), 32'd0);
      end
      tick();
      chk("drain_gap", 32'(pop_valid), 32'd0);
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);

    // Reset during RD_WAIT with two entries held
    pop_ready = 1'b0;
    push_one(8'hB0);
    push_one(8'hB1);
    push_one(8'hB2);
    pop_ready = 1'b1;
    #1;
    chk("pre_rst_ren", 32'(ram_ren), 32'd1);
    chk("pre_rst_addr", 32'(ram_address), 32'd3);
    tick();
    chk("rdwait_count", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
    chk("midrst_pop_data", 32'(pop_data), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ram_en", 32'({ram_ren, ram_wen}), 32'd0);
    chk("midrst_ram_bus", 32'({ram_address, ram_data_in}), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_push_ready", 32'(push_ready), 32'd1);
    repeat (4) begin
      tick();
      chk("post_rst_no_pop", 32'(pop_valid), 32'd0);
    end
    push_valid = 1'b1;
    push_data  = 8'hC5;
    #1;
    chk("post_rst_wr_addr", 32'(ram_address), 32'd0);
    tick();
    push_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_pop_valid", 32'(pop_valid), 32'd1);
    chk("post_rst_pop_data", 32'(pop_data), 32'hC5);
    tick();

`ifdef RAM_FIFO_CTRL_FLUSH_EN
    // Flush while a read is in flight with three entries held
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(8'(8'hD0 + i));
    pop_ready = 1'b1;
    #1;
    chk("pre_flush_ren", 32'(ram_ren), 32'd1);
    tick();
    chk("pre_flush_count", 32'(count), 32'd3);
    flush      = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'h77;
    #1;
    chk("flush_push_ready", 32'(push_ready), 32'd0);
    chk("flush_ram_en", 32'({ram_ren, ram_wen}), 32'd0);
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    #1;
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_pop_valid", 32'(pop_valid), 32'd0);
    repeat (3) begin
      tick();
      chk("post_flush_no_pop", 32'(pop_valid), 32'd0);
    end
    push_valid = 1'b1;
    push_data  = 8'hE7;
    #1;
    chk("post_flush_wr_addr", 32'(ram_address), 32'd0);
    tick();
    push_valid = 1'b0;
    tick();
    tick();
    chk("post_flush_pop_valid_new", 32'(pop_valid), 32'd1);
    chk("post_flush_pop_data", 32'(pop_data), 32'hE7);
    tick();
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
